// File: rtl/spi_cache_ctrl_if.sv
// Bundle of the CPU request/response, SPI refill and DFFRAM port signals of spi_cache_ctrl.
//   slave  : view taken by the cache controller (drives rsp/fill request/RAM/counter signals)
//   master : view taken by the surroundings (CPU, SPI flash reader, DFFRAM, stats reader)
// Signals:
//   req_valid_i / req_ready_o / req_addr_i     CPU word read request
//   rsp_valid_o / rsp_data_o                   one-cycle read response
//   invalidate_i                               clear all valid bits
//   fill_req_valid_o / fill_req_ready_i        line refill request, fill_addr_o line-aligned
//   fill_data_valid_i / fill_data_i            streamed refill words
//   ram_en_o / ram_we_o / ram_a_o / ram_di_o   DFFRAM EN0/WE0/A0/Di0
//   ram_do_i                                   DFFRAM Do0
//   hit_cnt_o / miss_cnt_o                     statistics counters
interface spi_cache_ctrl_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic [15:0]       rsp_data_o;
    logic              invalidate_i;
    logic              fill_req_valid_o;
    logic              fill_req_ready_i;
    logic [ADDR_W-1:0] fill_addr_o;
    logic              fill_data_valid_i;
    logic [15:0]       fill_data_i;
    logic              ram_en_o;
    logic [1:0]        ram_we_o;
    logic [9:0]        ram_a_o;
    logic [15:0]       ram_di_o;
    logic [15:0]       ram_do_i;
    logic [15:0]       hit_cnt_o;
    logic [15:0]       miss_cnt_o;

    modport slave (
        input  req_valid_i, req_addr_i, invalidate_i, fill_req_ready_i, fill_data_valid_i,
               fill_data_i, ram_do_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, fill_req_valid_o, fill_addr_o, ram_en_o,
               ram_we_o, ram_a_o, ram_di_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output req_valid_i, req_addr_i, invalidate_i, fill_req_ready_i, fill_data_valid_i,
               fill_data_i, ram_do_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, fill_req_valid_o, fill_addr_o, ram_en_o,
               ram_we_o, ram_a_o, ram_di_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/spi_cache_ctrl.sv
// Direct-mapped, read-only cache controller in front of a 256x16 DFFRAM. Serves 16-bit word
// reads; on a miss it requests the whole line from the SPI flash reader and writes the streamed
// words into the RAM, returning the requested word once the line is complete. Tags and valid
// bits live in flops here.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active high
//   bus    spi_cache_ctrl_if.slave (CPU side, refill side, RAM port, statistics)
// Parameters:
//   ADDR_W      CPU word-address width (tag = ADDR_W-8 bits)
//   LINE_WORDS  words per line, power of 2 in 2..16
// Build option:
//   CACHE_STATS_EN  when defined, hit_cnt_o/miss_cnt_o are saturating counters; otherwise 0.
module spi_cache_ctrl #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    spi_cache_ctrl_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = 8 - OFF_W;
    localparam int unsigned LINES = 256 / LINE_WORDS;
    localparam int unsigned TAG_W = ADDR_W - 8;

    typedef enum logic [2:0] {StIdle, StLookup, StFillReq, StFillData, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       cap_q, cap_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic              tag_we;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;

    assign off = addr_q[OFF_W-1:0];
    assign idx = addr_q[7:OFF_W];
    assign tag = addr_q[ADDR_W-1:8];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
        end
    end

    // Tags need no reset: a tag is only consulted when its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

    always_comb begin
        state_d              = state_q;
        addr_d               = addr_q;
        cnt_d                = cnt_q;
        cap_d                = cap_q;
        valid_d              = valid_q;
        tag_we               = 1'b0;
        bus.req_ready_o      = 1'b0;
        bus.rsp_valid_o      = 1'b0;
        bus.rsp_data_o       = '0;
        bus.fill_req_valid_o = 1'b0;
        bus.fill_addr_o      = '0;
        bus.ram_en_o         = 1'b0;
        bus.ram_we_o         = 2'b00;
        bus.ram_a_o          = '0;
        bus.ram_di_o         = '0;

        case (state_q)
            StIdle: begin
                // Invalidate wins over a simultaneous request and blocks its handshake.
                if (bus.invalidate_i) begin
                    valid_d = '0;
                end else begin
                    bus.req_ready_o = 1'b1;
                    if (bus.req_valid_i) begin
                        // Read the RAM speculatively so hit data is ready in LOOKUP.
                        addr_d       = bus.req_addr_i;
                        bus.ram_en_o = 1'b1;
                        bus.ram_a_o  = {2'b00, bus.req_addr_i[7:0]};
                        state_d      = StLookup;
                    end
                end
            end
            StLookup: begin
                if (hit) begin
                    bus.rsp_valid_o = 1'b1;
                    bus.rsp_data_o  = bus.ram_do_i;
                    state_d         = StIdle;
                end else begin
                    // Line is invalid until the refill fully completes (covers reset mid-fill).
                    valid_d[idx] = 1'b0;
                    state_d      = StFillReq;
                end
            end
            StFillReq: begin
                bus.fill_req_valid_o = 1'b1;
                bus.fill_addr_o      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (bus.fill_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = StFillData;
                end
            end
            StFillData: begin
                if (bus.fill_data_valid_i) begin
                    bus.ram_en_o = 1'b1;
                    bus.ram_we_o = 2'b11;
                    bus.ram_a_o  = {2'b00, idx, cnt_q};
                    bus.ram_di_o = bus.fill_data_i;
                    if (cnt_q == off) begin
                        cap_d = bus.fill_data_i;
                    end
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        valid_d[idx] = 1'b1;
                        tag_we       = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StResp: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_data_o  = cap_q;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        hit_ev, miss_ev;
    logic [15:0] hit_cnt_q, miss_cnt_q;

    assign hit_ev  = (state_q == StLookup) && hit;
    assign miss_ev = (state_q == StLookup) && !hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_ev && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (miss_ev && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`else
    assign bus.hit_cnt_o  = 16'h0;
    assign bus.miss_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_spi_cache_ctrl.sv
// Directed testbench for spi_cache_ctrl (ADDR_W=20, LINE_WORDS=4) with a behavioural 256x16
// DFFRAM model. Counter expectations follow whether CACHE_STATS_EN is defined.
module tb_spi_cache_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [15:0] mem [256];

    spi_cache_ctrl_if #(.ADDR_W(20)) bus ();

    spi_cache_ctrl #(
        .ADDR_W     (20),
        .LINE_WORDS (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DFFRAM model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            if (bus.ram_we_o == 2'b11) begin
                mem[bus.ram_a_o[7:0]] <= bus.ram_di_o;
            end else begin
                bus.ram_do_i <= mem[bus.ram_a_o[7:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] hits, input logic [15:0] misses);
`ifdef CACHE_STATS_EN
        check({tag, "_hit"}, bus.hit_cnt_o, hits);
        check({tag, "_miss"}, bus.miss_cnt_o, misses);
`else
        check({tag, "_hit"}, bus.hit_cnt_o, 16'h0);
        check({tag, "_miss"}, bus.miss_cnt_o, 16'h0);
`endif
    endtask

    task automatic accept(input logic [19:0] addr);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        #1;
        check("req_ready", bus.req_ready_o, 1);
        check("rd_en_we", {bus.ram_en_o, bus.ram_we_o}, 3'b100);
        check("rd_addr", bus.ram_a_o, {2'b00, addr[7:0]});
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic read_hit(input logic [19:0] addr, input logic [15:0] exp);
        accept(addr);
        @(negedge clk);
        check("hit_rsp_v", bus.rsp_valid_o, 1);
        check("hit_data", bus.rsp_data_o, exp);
        check("hit_nofill", bus.fill_req_valid_o, 0);
        @(negedge clk);
        check("hit_rsp_once", bus.rsp_valid_o, 0);
    endtask

    task automatic read_miss(input logic [19:0] addr, input logic [19:0] fa, input logic [15:0] base,
                             input int stall, input logic [15:0] exp);
        logic [7:0] wa;
        accept(addr);
        @(negedge clk);
        check("miss_norsp", bus.rsp_valid_o, 0);
        @(negedge clk);
        check("freq_v", bus.fill_req_valid_o, 1);
        check("freq_addr", bus.fill_addr_o, fa);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_v", bus.fill_req_valid_o, 1);
            check("stall_addr", bus.fill_addr_o, fa);
            check("stall_ready", bus.req_ready_o, 0);
        end
        bus.fill_req_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.fill_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(negedge clk);
                check("gap_ram_idle", {bus.ram_en_o, bus.ram_we_o}, 3'b000);
                check("gap_norsp", bus.rsp_valid_o, 0);
            end
            @(negedge clk);
            bus.fill_data_valid_i = 1'b1;
            bus.fill_data_i       = base + 16'(i);
            wa                    = fa[7:0] + 8'(i);
            #1;
            check("wr_en_we", {bus.ram_en_o, bus.ram_we_o}, 3'b111);
            check("wr_addr", bus.ram_a_o, {2'b00, wa});
            check("wr_data", bus.ram_di_o, base + 16'(i));
            check("wr_norsp", bus.rsp_valid_o, 0);
            @(posedge clk);
            #1;
            bus.fill_data_valid_i = 1'b0;
        end
        @(negedge clk);
        check("miss_rsp_v", bus.rsp_valid_o, 1);
        check("miss_data", bus.rsp_data_o, exp);
        @(negedge clk);
        check("miss_rsp_once", bus.rsp_valid_o, 0);
        check("back_idle", bus.req_ready_o, 1);
    endtask

    initial begin
        n_checks              = 0;
        n_pass                = 0;
        rst                   = 1'b1;
        bus.req_valid_i       = 1'b0;
        bus.req_addr_i        = '0;
        bus.invalidate_i      = 1'b0;
        bus.fill_req_ready_i  = 1'b0;
        bus.fill_data_valid_i = 1'b0;
        bus.fill_data_i       = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready_o, 1);
        check("rst_rsp", bus.rsp_valid_o, 0);
        check("rst_fill", bus.fill_req_valid_o, 0);
        check("rst_ram_en", bus.ram_en_o, 0);
        check_cnt("rst_cnt", 16'd0, 16'd0);
        rst = 1'b0;

        // Cold miss on word 5: line 4..7 refilled, word 1 of the line returned.
        read_miss(20'h00005, 20'h00004, 16'hA000, 0, 16'hA001);
        for (int i = 0; i < 4; i++) begin
            check("mem_line1", mem[4 + i], 16'hA000 + 16'(i));
        end

        // Hit in the same line, then a conflicting tag with a stalled refill request.
        read_hit(20'h00006, 16'hA002);
        read_miss(20'h00404, 20'h00404, 16'hB000, 5, 16'hB000);
        check_cnt("cnt_s12", 16'd1, 16'd2);

        // Invalidate beats a simultaneous request; the line must then refetch.
        read_hit(20'h00405, 16'hB001);
        @(negedge clk);
        bus.invalidate_i = 1'b1;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 20'h00006;
        #1;
        check("inv_ready", bus.req_ready_o, 0);
        check("inv_ram_en", bus.ram_en_o, 0);
        @(posedge clk);
        #1;
        bus.invalidate_i = 1'b0;
        bus.req_valid_i  = 1'b0;
        @(negedge clk);
        check("inv_norsp", bus.rsp_valid_o, 0);
        check("inv_noaccept", bus.req_ready_o, 1);
        read_miss(20'h00405, 20'h00404, 16'hB100, 0, 16'hB101);
        read_miss(20'h00006, 20'h00004, 16'hC000, 0, 16'hC002);
        check_cnt("cnt_s4", 16'd2, 16'd4);

        // Reset in the middle of a refill.
        accept(20'h00010);
        repeat (2) @(negedge clk);
        check("rf_freq_v", bus.fill_req_valid_o, 1);
        bus.fill_req_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.fill_req_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.fill_data_valid_i = 1'b1;
            bus.fill_data_i       = 16'h9000 + 16'(i);
            @(posedge clk);
            #1;
            bus.fill_data_valid_i = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rf_ready", bus.req_ready_o, 1);
        check("rf_rsp", bus.rsp_valid_o, 0);
        check("rf_fill", bus.fill_req_valid_o, 0);
        check("rf_ram", {bus.ram_en_o, bus.ram_we_o}, 3'b000);
        check_cnt("rf_cnt", 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rf_no_rsp", bus.rsp_valid_o, 0);
        end
        read_miss(20'h00010, 20'h00010, 16'hD000, 0, 16'hD000);
        read_miss(20'h00006, 20'h00004, 16'hE000, 0, 16'hE002);
        read_hit(20'h00011, 16'hD001);
        check_cnt("cnt_s5", 16'd1, 16'd2);

`ifdef CACHE_STATS_EN
        // Saturation: preload the hit counter at its ceiling, then hit once more.
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        read_hit(20'h00012, 16'hD002);
        check("hit_sat", bus.hit_cnt_o, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
